// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory (CPU load/store path and debug/DMA port).
// Default: fixed CPU priority with a DMA starvation guard; define ARB_ROUND_ROBIN_EN for round-robin.
module dmem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int AW         = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [AW-1:0]    dma_addr,
    input  logic [WIDTH-1:0] dma_wdata,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [WIDTH-1:0] dma_rdata,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wr,
    output logic             mem_rd,
    input  logic [WIDTH-1:0] mem_rdata
);

    logic             dma_win;
    logic             rd_pend_q;
    logic             rd_owner_q;
    logic [WIDTH-1:0] cpu_hold_q;
    logic [WIDTH-1:0] dma_hold_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q;

    // On contention the port that was not granted last wins.
    assign dma_win = ~cpu_req | ~rr_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b0;
        end else if (dma_gnt) begin
            rr_last_q <= 1'b1;
        end else if (cpu_gnt) begin
            rr_last_q <= 1'b0;
        end
    end
`else
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       force_dma;

    assign force_dma = (starve_cnt_q == 4'(STARVE_MAX));
    assign dma_win   = ~cpu_req | force_dma;

    // Counts consecutive losing cycles of the DMA port, saturating at STARVE_MAX.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (~dma_req | dma_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (!force_dma) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign dma_gnt   = ~rst & dma_req & dma_win;
    assign cpu_gnt   = ~rst & cpu_req & ~dma_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_wr    = dma_we;
            mem_rd    = ~dma_we;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wr    = cpu_we;
            mem_rd    = ~cpu_we;
        end
    end

    // Return data is forwarded in the return cycle and captured to hold afterwards.
    assign cpu_rvalid = rd_pend_q & ~rd_owner_q;
    assign dma_rvalid = rd_pend_q & rd_owner_q;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            cpu_hold_q <= '0;
            dma_hold_q <= '0;
        end else begin
            rd_pend_q  <= mem_rd;
            rd_owner_q <= dma_gnt;
            if (cpu_rvalid) begin
                cpu_hold_q <= mem_rdata;
            end
            if (dma_rvalid) begin
                dma_hold_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked against a
// behavioural model of arbitration, a reference memory and the read-return rules.
module tb_dmem_arbiter;
    localparam int WIDTH      = 32;
    localparam int AW         = 14;
    localparam int STARVE_MAX = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0]    cpu_addr, dma_addr, mem_addr;
    logic [WIDTH-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic             cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_wr, mem_rd;
    logic [WIDTH-1:0] cpu_rdata, dma_rdata;

    dmem_arbiter #(.WIDTH(WIDTH), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory device with one-cycle read latency.
    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Reference model state.
    logic [WIDTH-1:0] ref_mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] exp_q[$];
    logic             pend_valid, pend_owner;
    logic [WIDTH-1:0] cpu_hold, dma_hold;
    int               dwait;
    logic             rr_last;
    int               n_cmp = 0;
    int               n_fail = 0;

    // Observations from the most recent step, for directed checks.
    logic             obs_cg, obs_dg, obs_stall, obs_cv, obs_dv;
    logic [WIDTH-1:0] obs_crdata, obs_drdata;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs mid-cycle against the model, advance the model,
    // optionally raise rst before the edge, then return just after the edge.
    task automatic step(input bit pulse_rst);
        logic             e_cg, e_dg, e_cv, e_dv;
        logic [AW-1:0]    e_addr;
        logic [WIDTH-1:0] e_wdata;
        @(negedge clk);
        if (rst) begin
            pend_valid = 1'b0; exp_q.delete();
            cpu_hold = '0; dma_hold = '0; dwait = 0; rr_last = 1'b0;
            e_dg = 1'b0; e_cg = 1'b0;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            e_dg = dma_req && (!cpu_req || !rr_last);
`else
            e_dg = dma_req && (!cpu_req || dwait >= STARVE_MAX);
`endif
            e_cg = cpu_req && !e_dg;
        end
        e_cv = pend_valid && !pend_owner;
        e_dv = pend_valid && pend_owner;
        if (pend_valid) begin
            if (pend_owner) dma_hold = exp_q.pop_front();
            else            cpu_hold = exp_q.pop_front();
        end
        e_addr  = e_dg ? dma_addr  : (e_cg ? cpu_addr  : '0);
        e_wdata = e_dg ? dma_wdata : (e_cg ? cpu_wdata : '0);
        chk("cpu_gnt", cpu_gnt, e_cg);
        chk("dma_gnt", dma_gnt, e_dg);
        chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
        chk("mem_wr", mem_wr, (e_dg && dma_we) || (e_cg && cpu_we));
        chk("mem_rd", mem_rd, (e_dg && !dma_we) || (e_cg && !cpu_we));
        chk("mem_addr", WIDTH'(mem_addr), WIDTH'(e_addr));
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("cpu_rvalid", cpu_rvalid, e_cv);
        chk("dma_rvalid", dma_rvalid, e_dv);
        chk("cpu_rdata", cpu_rdata, cpu_hold);
        chk("dma_rdata", dma_rdata, dma_hold);
        obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_stall = cpu_stall;
        obs_cv = cpu_rvalid; obs_dv = dma_rvalid; obs_crdata = cpu_rdata; obs_drdata = dma_rdata;
        pend_valid = 1'b0;
        if (!rst) begin
            if (e_dg) begin
                if (dma_we) ref_mem[dma_addr] = dma_wdata;
                else begin pend_valid = 1'b1; pend_owner = 1'b1; exp_q.push_back(ref_mem[dma_addr]); end
            end
            if (e_cg) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else begin pend_valid = 1'b1; pend_owner = 1'b0; exp_q.push_back(ref_mem[cpu_addr]); end
            end
            if (dma_req && !e_dg) dwait = (dwait < STARVE_MAX) ? dwait + 1 : dwait;
            else                  dwait = 0;
            if (e_dg)      rr_last = 1'b1;
            else if (e_cg) rr_last = 1'b0;
        end
        if (pulse_rst) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        bit c_act, d_act;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = WIDTH'(i * 32'h9E37_79B9);
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h11; ref_mem[3] = 32'h11;
        mem[4] = 32'h22; ref_mem[4] = 32'h22;
        pend_valid = 0; pend_owner = 0; cpu_hold = '0; dma_hold = '0; dwait = 0; rr_last = 0;
        idle_inputs();

        // Reset with a CPU request pending.
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 14'd9;
        step(0);
        chk("rst_cpu_gnt", obs_cg, 1'b0);
        chk("rst_cpu_stall", obs_stall, 1'b1);
        step(0);
        rst = 1'b0; idle_inputs();
        step(0);

        // CPU store then load at address 5.
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'd5; cpu_wdata = 32'hDEADBEEF;
        step(0);
        chk("store_gnt", obs_cg, 1'b1);
        cpu_we = 0;
        step(0);
        chk("load_gnt", obs_cg, 1'b1);
        cpu_req = 0;
        step(0);
        chk("load_rvalid", obs_cv, 1'b1);
        chk("load_rdata", obs_crdata, 32'hDEADBEEF);
        chk("load_dma_rvalid", obs_dv, 1'b0);

        // Interleaved reads: DMA at 3, then CPU at 4.
        dma_req = 1; dma_we = 0; dma_addr = 14'd3;
        step(0);
        dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 14'd4;
        step(0);
        chk("il_dma_rvalid", obs_dv, 1'b1);
        chk("il_dma_rdata", obs_drdata, 32'h11);
        chk("il_cpu_rvalid_n1", obs_cv, 1'b0);
        cpu_req = 0;
        step(0);
        chk("il_cpu_rvalid", obs_cv, 1'b1);
        chk("il_cpu_rdata", obs_crdata, 32'h22);
        chk("il_dma_rvalid_n2", obs_dv, 1'b0);

        // Continuous contention from reset.
        rst = 1'b1; step(0); rst = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'd7;
        dma_req = 1; dma_we = 0; dma_addr = 14'd8;
        for (int i = 0; i < 10; i++) begin
            step(0);
`ifdef ARB_ROUND_ROBIN_EN
            chk($sformatf("rr_dma_gnt_%0d", i), obs_dg, (i % 2) == 0);
`else
            chk($sformatf("starve_dma_gnt_%0d", i), obs_dg, (i == 4) || (i == 9));
            chk($sformatf("starve_stall_%0d", i), obs_stall, (i == 4) || (i == 9));
`endif
        end
        idle_inputs();
        step(0);
        step(0);

        // Reset between a CPU read grant and its return.
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'd5;
        step(1);
        chk("mid_read_gnt", obs_cg, 1'b1);
        idle_inputs();
        step(0);
        rst = 1'b0;
        step(0);
        chk("mid_read_rvalid", obs_cv, 1'b0);
        chk("mid_read_rdata", obs_crdata, '0);

        // Random traffic on a small address window to provoke collisions.
        c_act = 0; d_act = 0;
        for (int n = 0; n < 400; n++) begin
            if (c_act && $urandom_range(0, 19) == 0) c_act = 0;
            else if (!c_act && $urandom_range(0, 9) < 6) begin
                c_act = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = $urandom;
            end
            if (d_act && $urandom_range(0, 19) == 0) d_act = 0;
            else if (!d_act && $urandom_range(0, 9) < 5) begin
                d_act = 1; dma_we = 1'($urandom_range(0, 1));
                dma_addr = AW'($urandom_range(0, 15)); dma_wdata = $urandom;
            end
            cpu_req = c_act; dma_req = d_act;
            if (!c_act) begin cpu_we = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom); cpu_wdata = $urandom; end
            if (!d_act) begin dma_we = 1'($urandom_range(0, 1)); dma_addr = AW'($urandom); dma_wdata = $urandom; end
            step(0);
            if (obs_cg) c_act = 0;
            if (obs_dg) d_act = 0;
        end
        idle_inputs();
        step(0);
        step(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
